// File: rtl/ahb_mem_pkg.sv
// Shared types and helpers for the AHB-style memory responder.
package ahb_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] BUSY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        WAIT
    } state_e;

    // True when addr lands inside the 2**addr_w word window starting at base.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned addr_w);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/ahb_mem_responder_if.sv
// Bus-side signals of the memory responder: address/data phase plus hready handshake.
interface ahb_mem_responder_if;
    import ahb_mem_pkg::*;

    logic              hsel;
    logic [31:0]       haddr;
    logic              hwrite;
    logic [WORD_W-1:0] hwdata;
    logic [WORD_W-1:0] hrdata;
    logic              hready;

    modport master (output hsel, haddr, hwrite, hwdata, input hrdata, hready);
    modport slave  (input hsel, haddr, hwrite, hwdata, output hrdata, hready);
endinterface

// File: rtl/mem_array_1rw.sv
// Word array: synchronous write, combinational read, plus a backdoor load/peek port.
module mem_array_1rw
    import ahb_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [WORD_W-1:0] bd_wdata,
    output logic [WORD_W-1:0] bd_rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Bus write is issued last so it overrides a backdoor write to the same word.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        if (we)    mem[waddr]   <= wdata;
    end

    assign rdata    = mem[raddr];
    assign bd_rdata = mem[bd_addr];

endmodule

// File: rtl/ahb_mem_responder.sv
// Word-addressed AHB-style memory responder with backdoor port and out-of-range counter.
// Define WAIT_STATE_EN to insert WAIT_CYCLES wait states before every data phase.
module ahb_mem_responder
    import ahb_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    ahb_mem_responder_if.slave  bus,
    input  logic                bd_we,
    input  logic [ADDR_W-1:0]   bd_addr,
    input  logic [WORD_W-1:0]   bd_wdata,
    output logic [WORD_W-1:0]   bd_rdata,
    output logic [15:0]         oob_count
);
    localparam logic [15:0] OOB_MAX = 16'hFFFF;

    state_e            state_q, state_d;
    logic              capture, cap_inr;
    logic [ADDR_W-1:0] cap_idx;
    logic              ph_write, ph_inr;
    logic [ADDR_W-1:0] ph_idx;
    logic              rd_write, rd_inr;
    logic [ADDR_W-1:0] rd_idx;
    logic              bus_we;
    logic [WORD_W-1:0] arr_rdata, rd_data;

`ifdef WAIT_STATE_EN
    localparam state_e CAP_STATE = (WAIT_CYCLES == 0) ? DATA : WAIT;
    logic [3:0] wait_cnt_q;
`else
    localparam state_e CAP_STATE = DATA;
    // WAIT_CYCLES only matters in the wait-state build.
    logic [3:0] unused_wait_cycles;
    assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

    assign capture = bus.hsel && bus.hready;
    assign cap_inr = in_range(bus.haddr, BASE_ADDR, ADDR_W);
    assign cap_idx = ADDR_W'((bus.haddr - BASE_ADDR) >> 2);

    // Reset on the completing edge abandons the write.
    assign bus_we = (state_q == DATA) && ph_write && ph_inr && n_rst;

    // hrdata source: a fresh capture in zero-wait entry, otherwise the held phase.
    assign rd_write = capture ? bus.hwrite : ph_write;
    assign rd_inr   = capture ? cap_inr    : ph_inr;
    assign rd_idx   = capture ? cap_idx    : ph_idx;

    always_comb begin
        rd_data = '0;
        if (rd_inr) rd_data = (bus_we && (ph_idx == rd_idx)) ? bus.hwdata : arr_rdata;
    end

    mem_array_1rw #(.ADDR_W(ADDR_W)) u_mem (
        .clk      (clk),
        .we       (bus_we),
        .waddr    (ph_idx),
        .wdata    (bus.hwdata),
        .raddr    (rd_idx),
        .rdata    (arr_rdata),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DATA: state_d = capture ? CAP_STATE : IDLE;
`ifdef WAIT_STATE_EN
            WAIT:       if (wait_cnt_q == 4'd1) state_d = DATA;
`endif
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.hready = 1'b1;
`ifdef WAIT_STATE_EN
        if (state_q == WAIT) bus.hready = 1'b0;
`endif
    end

`ifdef WAIT_STATE_EN
    always_ff @(posedge clk) begin
        if (!n_rst)                wait_cnt_q <= '0;
        else if (capture)          wait_cnt_q <= 4'(WAIT_CYCLES);
        else if (state_q == WAIT)  wait_cnt_q <= wait_cnt_q - 4'd1;
    end
`endif

    // Phase capture, read-data load on DATA entry, out-of-range accounting.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ph_write   <= 1'b0;
            ph_inr     <= 1'b0;
            ph_idx     <= '0;
            bus.hrdata <= '0;
            oob_count  <= '0;
        end else begin
            if (capture) begin
                ph_write <= bus.hwrite;
                ph_inr   <= cap_inr;
                ph_idx   <= cap_idx;
            end
            if ((state_d == DATA) && !rd_write) bus.hrdata <= rd_data;
            if ((state_q == DATA) && !ph_inr && (oob_count != OOB_MAX))
                oob_count <= oob_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Self-checking bench for ahb_mem_responder: vector table, scoreboard-driven bus driver, corner sequences.
module tb_ahb_mem_responder;
    import ahb_mem_pkg::*;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned N_STREAM = 256;
    localparam int unsigned N_VEC    = 10;
    localparam int          TIMEOUT  = 5000;
`ifdef WAIT_STATE_EN
    localparam int unsigned EXP_WAITS = 2;
`else
    localparam int unsigned EXP_WAITS = 0;
`endif

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_oob;
    } vec_t;

    logic              tb_clk = 1'b0;
    logic              n_rst;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_wdata;
    logic [31:0]       bd_rdata;
    logic [15:0]       oob_count;

    int          tests = 0;
    int          fails = 0;
    vec_t        txq[$];
    logic [31:0] exp_q[$];
    bit          bd_collide;
    logic [11:0] col_addr;
    logic [31:0] col_data;

    ahb_mem_responder_if bus ();

    ahb_mem_responder #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .bus       (bus),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata),
        .oob_count (oob_count)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic bd_write(input int unsigned idx, input logic [31:0] d);
        bd_we    = 1'b1;
        bd_addr  = 12'(idx);
        bd_wdata = d;
        cyc();
        bd_we    = 1'b0;
    endtask

    task automatic bd_peek(input int unsigned idx, output logic [31:0] d);
        bd_addr = 12'(idx);
        #1;
        d = bd_rdata;
    endtask

    task automatic push(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e);
        vec_t v;
        v = '{write: w, addr: a, wdata: wd, exp_rdata: e, exp_oob: 16'd0};
        txq.push_back(v);
    endtask

    // Issues txq back-to-back; read expectations go to exp_q at address phase, popped at data phase.
    task automatic drain(output int cycles, output int waits);
        vec_t        cur;
        bit          pend = 1'b0;
        int          i = 0;
        logic [31:0] e;
        cycles = 0;
        waits  = 0;
        cur    = '{write: 1'b0, addr: 32'h0, wdata: 32'h0, exp_rdata: 32'h0, exp_oob: 16'h0};
        while ((i < txq.size() || pend) && cycles < TIMEOUT) begin
            if (bus.hready) begin
                if (pend) begin
                    if (cur.write) begin
                        bus.hwdata = cur.wdata;
                        if (bd_collide) begin
                            bd_we    = 1'b1;
                            bd_addr  = col_addr;
                            bd_wdata = col_data;
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("hrdata", bus.hrdata, e);
                    end
                end
                if (i < txq.size()) begin
                    cur        = txq[i];
                    i++;
                    bus.hsel   = 1'b1;
                    bus.haddr  = cur.addr;
                    bus.hwrite = cur.write;
                    if (!cur.write) exp_q.push_back(cur.exp_rdata);
                    pend = 1'b1;
                end else begin
                    bus.hsel = 1'b0;
                    pend     = 1'b0;
                end
            end else begin
                waits++;
            end
            cyc();
            cycles++;
            bd_we = 1'b0;
        end
        if (cycles >= TIMEOUT) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d cycles, required fewer than %0d", cycles, TIMEOUT);
        end
        bus.hsel = 1'b0;
        txq.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [N_VEC];
        int          cyc_n;
        int          wait_n;
        logic [31:0] d;

        n_rst      = 1'b0;
        bus.hsel   = 1'b0;
        bus.haddr  = 32'h0;
        bus.hwrite = 1'b0;
        bus.hwdata = 32'h0;
        bd_we      = 1'b0;
        bd_addr    = '0;
        bd_wdata   = 32'h0;
        bd_collide = 1'b0;
        col_addr   = 12'h0;
        col_data   = 32'h0;

        vt[0] = '{1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF, 16'd0};
        vt[1] = '{1'b1, 32'h0000_0028, 32'h1111_2222, 32'h0,         16'd0};
        vt[2] = '{1'b0, 32'h0000_0028, 32'h0,         32'h1111_2222, 16'd0};
        vt[3] = '{1'b0, 32'h0000_0024, 32'h0,         BUSY_WORD,     16'd0};
        vt[4] = '{1'b0, 32'h0000_4000, 32'h0,         32'h0,         16'd1};
        vt[5] = '{1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 32'h0,         16'd2};
        vt[6] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 16'd2};
        vt[7] = '{1'b0, 32'h0000_0017, 32'h0,         32'hDEAD_BEEF, 16'd2};
        vt[8] = '{1'b0, 32'h0000_3FFC, 32'h0,         32'hCAFE_0FFF, 16'd2};
        vt[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         16'd3};

        cyc();
        cyc();
        check("rst_hready", 32'(bus.hready), 32'd1);
        check("rst_hrdata", bus.hrdata, 32'h0);
        check("rst_oob", 32'(oob_count), 32'd0);
        n_rst = 1'b1;

        bd_write(5, 32'hDEAD_BEEF);
        bd_write(9, BUSY_WORD);
        bd_write(0, 32'h0BAD_F00D);
        bd_write(4095, 32'hCAFE_0FFF);
        bd_write(8, 32'h0);
        bd_write(10, 32'h0);
        bd_write(12, 32'h3333_3333);

        for (int k = 0; k < int'(N_VEC); k++) begin
            txq.push_back(vt[k]);
            drain(cyc_n, wait_n);
            check("vec_oob", 32'(oob_count), 32'(vt[k].exp_oob));
            check("vec_waits", 32'(wait_n), 32'(EXP_WAITS));
        end

        // Write then read of the same word back to back exercises the bypass path.
        push(1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0);
        push(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);
        drain(cyc_n, wait_n);
        check("b2b_cycles", 32'(cyc_n), 32'(3 + 2 * EXP_WAITS));
        bd_peek(8, d);
        check("bd_rdata_8", d, 32'h1234_5678);

        // Backdoor and bus write to the same word on the same edge.
        bd_collide = 1'b1;
        col_addr   = 12'd8;
        col_data   = 32'hBD0B_D0BD;
        push(1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0);
        drain(cyc_n, wait_n);
        bd_collide = 1'b0;
        bd_peek(8, d);
        check("collide_bus_wins", d, 32'h5555_AAAA);
        check("hrdata_hold", bus.hrdata, 32'h1234_5678);

        // Reset right after a write address phase abandons the write.
        bus.hsel   = 1'b1;
        bus.haddr  = 32'h0000_0030;
        bus.hwrite = 1'b1;
        cyc();
        bus.hsel   = 1'b0;
        bus.hwdata = 32'hBADB_AD00;
        n_rst      = 1'b0;
        cyc();
        check("rstmid_hready", 32'(bus.hready), 32'd1);
        check("rstmid_hrdata", bus.hrdata, 32'h0);
        n_rst = 1'b1;
        repeat (4) cyc();
        bd_peek(12, d);
        check("rstmid_word", d, 32'h3333_3333);
        check("rstmid_oob", 32'(oob_count), 32'd0);

        for (int k = 0; k < int'(N_STREAM); k++)
            bd_write(256 + k, 32'h5A00_0000 + 32'(k * 3));
        for (int k = 0; k < int'(N_STREAM); k++)
            push(1'b0, 32'((256 + k) * 4), 32'h0, 32'h5A00_0000 + 32'(k * 3));
        drain(cyc_n, wait_n);
        check("stream_cycles", 32'(cyc_n), 32'(N_STREAM + 1 + N_STREAM * EXP_WAITS));
        check("stream_waits", 32'(wait_n), 32'(N_STREAM * EXP_WAITS));
        check("stream_oob", 32'(oob_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
- Word-addressed AHB-style memory responder. It is the far end of the AHB_wrapper master port: it accepts m_haddr/m_hwrite address phases and returns m_hrdata or absorbs m_hwdata, with m_hready handshaking.
- Serves as the frame-memory model for system-level simulation of the edge-detection pipeline and as a synthesizable on-chip scratch buffer.
- Includes a backdoor load/peek port so benches can preload image words and check results without bus traffic.

Parameters:
- ADDR_W, 12, word-index width; depth = 2**ADDR_W words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- WAIT_CYCLES, 2, wait states inserted per data phase (used only when WAIT_STATE_EN is defined; legal range 0-15).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- hsel  in  1  transfer request qualifier for the address phase.
- haddr  in  32  byte address; bits [1:0] are ignored.
- hwrite  in  1  1 = write, 0 = read; sampled in the address phase.
- hwdata  in  32  write data; valid during the write data phase.
- hrdata  out  32  read data; valid when hready=1 in a read data phase.
- hready  out  1  data phase completes this cycle and the responder can accept a new address phase.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  ADDR_W  backdoor word index.
- bd_wdata  in  32  backdoor write data.
- bd_rdata  out  32  combinational array read at bd_addr.
- oob_count  out  16  saturating count of out-of-range accesses.

Behaviour:
- Reset (n_rst=0 at a rising edge): state=IDLE, hready=1, hrdata=0, oob_count=0, pending phase cleared. Array contents are not reset.
- Reset mid-transfer abandons the pending phase; no array write occurs.
- Address phase: captured at a rising edge where hsel=1 and hready=1. Capture haddr, hwrite, and in-range = ((haddr-BASE_ADDR)>>2) < 2**ADDR_W and haddr>=BASE_ADDR. Word index = (haddr-BASE_ADDR)[ADDR_W+1:2].
- hsel=0, or hready=0: nothing is captured.
- FSM states: IDLE, DATA, WAIT.
  - IDLE -> DATA after a capture (zero-wait build).
  - IDLE -> WAIT after a capture when WAIT_STATE_EN and WAIT_CYCLES>0.
  - WAIT: hready=0; a 4-bit counter counts down WAIT_CYCLES. On reaching 1 -> DATA.
  - DATA: hready=1; the data phase completes this cycle.
  - If hsel=1 in DATA, a new address phase is captured in the same cycle (pipelined): go to DATA or WAIT accordingly. Otherwise go to IDLE.
- Read latency: zero-wait gives hrdata valid in the cycle after the address phase. hrdata is registered and loaded on entry to the DATA cycle.
- Write: hwdata is sampled at the rising edge that ends the DATA cycle; the array is written at that edge.
- Hazard forwarding: a write data phase to word A in cycle n, followed by a read address phase of A in cycle n, must return the hwdata of cycle n (bypass), not stale array data.
- Out-of-range access: reads return 32'h0, writes are dropped, oob_count increments once per completed data phase and saturates at 16'hFFFF. hready timing is unchanged.
- Backdoor: bd_we writes at a rising edge. If a bus write to the same word completes at the same edge, the bus write wins.
- hrdata holds its last value outside read data phases.

Optional Feature:
- Macro WAIT_STATE_EN.
  - Defined: each data phase is preceded by WAIT_CYCLES cycles with hready=0; WAIT_CYCLES=0 behaves as the zero-wait build.
  - Undefined: the WAIT state and counter are not compiled; hready=1 except never low; zero-wait operation throughout.

Decomposition:
- Package ahb_mem_pkg holds:
  - state typedef enum {IDLE, DATA, WAIT};
  - WORD_W=32;
  - BUSY_WORD=32'hFFFF_FFFF (shared with AHB_wrapper status polling);
  - the in-range check function.
- Sub-module mem_array_1rw: synchronous-write, combinational-read 32-bit array with the backdoor port muxed in.

Test Plan:
- Backdoor preload word 5=32'hDEAD_BEEF; bus read haddr=32'h14, zero-wait -> hready=1 throughout, hrdata=32'hDEAD_BEEF in the next cycle.
- Bus write 32'h1234_5678 to haddr=32'h20, then back-to-back read of 32'h20 -> hrdata=32'h1234_5678 via bypass; bd_rdata at index 8 also matches.
- WAIT_STATE_EN, WAIT_CYCLES=2: read of 32'h14 -> hready low for exactly 2 cycles, then high with hrdata=32'hDEAD_BEEF.
- Read haddr=BASE_ADDR+(4<<ADDR_W) -> hrdata=0 and oob_count=1; a write there leaves the array unchanged and sets oob_count=2.
- Assert n_rst=0 during WAIT of a pending write -> next cycle hready=1, state IDLE, target word unchanged.
- Streaming 256 consecutive reads with hsel held high -> one word per cycle in zero-wait mode; data matches the preloaded incrementing pattern.
